vend_ctrl: RTL and testbench

Credit and sequencing controller for the Lab3 vending machine. It accumulates inserted coins as nickel-unit credit and presents that credit to the dispense block as its coin value. It gates the dispense block's enable and applies the block's down_5/10/25 charge pulses to the credit. It then pays out remaining credit as change on completion, on customer coin return, or on inactivity timeout.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_if.sv | 25 ++
 rtl/vend_refund.sv | 60 ++++++
 rtl/vend_ctrl.sv | 128 ++++++++++++
 tb/tb_vend_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Credit is counted in nickel units.
package vend_pkg;

  localparam int CREDIT_W = 6;

  localparam logic [3:0] U5  = 4'd1;
  localparam logic [3:0] U10 = 4'd2;
  localparam logic [3:0] U25 = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_REFUND = 2'd3
  } state_t;

  // Nickel-unit value of any combination of 5/10/25 strobes.
  function automatic logic [3:0] units(input logic c5, input logic c10, input logic c25);
    return (c5 ? U5 : 4'd0) + (c10 ? U10 : 4'd0) + (c25 ? U25 : 4'd0);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Coin mech, dispense block and change hopper signals of the vending controller.
interface vend_if;
  import vend_pkg::*;

  logic                coin_5, coin_10, coin_25, coin_return;
  logic                disp_done, disp_failed;
  logic                disp_down_5, disp_down_10, disp_down_25;
  logic                disp_enable;
  logic [CREDIT_W-1:0] credit;
  logic                ret_5, ret_10, ret_25;
  logic                coin_reject, busy, fault;

  modport master (
    output coin_5, coin_10, coin_25, coin_return,
    output disp_done, disp_failed, disp_down_5, disp_down_10, disp_down_25,
    input  disp_enable, credit, ret_5, ret_10, ret_25, coin_reject, busy, fault
  );

  modport slave (
    input  coin_5, coin_10, coin_25, coin_return,
    input  disp_done, disp_failed, disp_down_5, disp_down_10, disp_down_25,
    output disp_enable, credit, ret_5, ret_10, ret_25, coin_reject, busy, fault
  );

endinterface

// File: rtl/vend_refund.sv
// Change payout: paces hopper pulses and picks the largest coin that fits the credit.
// dec is the value of the coin being raised this edge so the owner can debit credit.
module vend_refund
  import vend_pkg::*;
#(
  parameter int PACE_TICKS = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  output logic                ret_5,
  output logic                ret_10,
  output logic                ret_25,
  output logic [CREDIT_W-1:0] dec
);

  localparam int PACE_W = (PACE_TICKS > 1) ? $clog2(PACE_TICKS) : 1;

  logic [PACE_W-1:0] pace;
  logic              fire;
  logic [2:0]        pick;

  // pace is zero while idle so the first coin goes out on the first refund edge
  always_comb begin
    fire = start && (credit != '0) && (pace == '0);
    pick = 3'b000;
    dec  = '0;
    if (fire) begin
      if (credit >= CREDIT_W'(U25)) begin
        pick = 3'b100;
        dec  = CREDIT_W'(U25);
      end else if (credit >= CREDIT_W'(U10)) begin
        pick = 3'b010;
        dec  = CREDIT_W'(U10);
      end else begin
        pick = 3'b001;
        dec  = CREDIT_W'(U5);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace   <= '0;
      ret_25 <= 1'b0;
      ret_10 <= 1'b0;
      ret_5  <= 1'b0;
    end else begin
      {ret_25, ret_10, ret_5} <= pick;
      if (!start)
        pace <= '0;
      else if (fire)
        pace <= PACE_W'(PACE_TICKS - 1);
      else if (pace != '0)
        pace <= pace - PACE_W'(1);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Credit and sequencing controller: accumulates coins, gates the dispense block,
// applies its charges and pays out the remainder as change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TIMEOUT_SEC   = 10,
  parameter int PACE_TICKS    = 250
) (
  input  logic clk,
  input  logic reset,
  vend_if.slave bus
);

  localparam int TO_CYC = TICKS_PER_SEC * TIMEOUT_SEC;
  localparam int TMR_W  = $clog2(TO_CYC + 1);
  localparam int CW1    = CREDIT_W + 1;
  localparam logic [CW1-1:0] CREDIT_MAX = CW1'((1 << CREDIT_W) - 1);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, dec;
  logic [TMR_W-1:0]    tmr;
  logic [3:0]          coin_u, chg_u;
  logic [CW1-1:0]      with_coin;
  logic                coin_ok, expired, tmr_clr, reject_n, fault_n;
  logic                disp_enable_q, busy_q, reject_q, fault;

  function automatic logic [CW1-1:0] add_coin(input logic [CREDIT_W-1:0] c, input logic [3:0] u);
    return {1'b0, c} + CW1'(u);
  endfunction

  function automatic logic underflow(input logic [CW1-1:0] a, input logic [3:0] u);
    return CW1'(u) > a;
  endfunction

  function automatic logic [CREDIT_W-1:0] sat_sub(input logic [CW1-1:0] a, input logic [3:0] u);
    return underflow(a, u) ? '0 : CREDIT_W'(a - CW1'(u));
  endfunction

  always_comb begin
    coin_u    = units(bus.coin_5, bus.coin_10, bus.coin_25);
    chg_u     = units(bus.disp_down_5, bus.disp_down_10, bus.disp_down_25);
    coin_ok   = (coin_u != 4'd0) && (add_coin(credit, coin_u) <= CREDIT_MAX);
    with_coin = coin_ok ? add_coin(credit, coin_u) : {1'b0, credit};
    expired   = (tmr == TMR_W'(TO_CYC - 1));
    state_n   = state;
    credit_n  = credit;
    reject_n  = 1'b0;
    fault_n   = fault;
    tmr_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin_ok) begin
          credit_n = CREDIT_W'(with_coin);
          state_n  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        // a coin arriving with a charge or a return is still banked first
        reject_n = (coin_u != 4'd0) && !coin_ok;
        tmr_clr  = coin_ok || bus.disp_failed;
        credit_n = sat_sub(with_coin, chg_u);
        fault_n  = fault | underflow(with_coin, chg_u);
        if (chg_u != 4'd0)
          state_n = S_VEND;
        else if (bus.coin_return || (expired && !tmr_clr))
          state_n = S_REFUND;
      end
      S_VEND: begin
        reject_n = (coin_u != 4'd0);
        credit_n = sat_sub({1'b0, credit}, chg_u);
        fault_n  = fault | underflow({1'b0, credit}, chg_u);
        if (bus.disp_done)
          state_n = (credit_n != '0) ? S_REFUND : S_IDLE;
        else if (bus.disp_failed)
          state_n = S_CREDIT;
      end
      S_REFUND: begin
        reject_n = (coin_u != 4'd0);
        credit_n = credit - dec;
        if (credit == '0)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      credit        <= '0;
      tmr           <= '0;
      disp_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      reject_q      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      fault         <= fault_n;
      reject_q      <= reject_n;
      disp_enable_q <= (state_n == S_CREDIT) || (state_n == S_VEND);
      busy_q        <= (state_n == S_VEND) || (state_n == S_REFUND);
      if ((state == S_CREDIT) && !tmr_clr)
        tmr <= tmr + TMR_W'(1);
      else
        tmr <= '0;
    end
  end

  vend_refund #(.PACE_TICKS(PACE_TICKS)) u_refund (
    .clk    (clk),
    .reset  (reset),
    .start  (state == S_REFUND),
    .credit (credit),
    .ret_5  (bus.ret_5),
    .ret_10 (bus.ret_10),
    .ret_25 (bus.ret_25),
    .dec    (dec)
  );

  assign bus.disp_enable = disp_enable_q;
  assign bus.credit      = credit;
  assign bus.coin_reject = reject_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed and randomized bench for vend_ctrl; expected credit and change are
// derived from coin arithmetic and the greedy 25/10/5 payout rule.
module tb_vend_ctrl;

  localparam int TPS  = 1000;
  localparam int TOS  = 10;
  localparam int PACE = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_if bus();

  vend_ctrl #(.TICKS_PER_SEC(TPS), .TIMEOUT_SEC(TOS), .PACE_TICKS(PACE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int got_coin[$];
  int got_cyc[$];
  int got_cred[$];
  bit multi;
  bit timed_out;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.coin_5 = 0; bus.coin_10 = 0; bus.coin_25 = 0; bus.coin_return = 0;
    bus.disp_done = 0; bus.disp_failed = 0;
    bus.disp_down_5 = 0; bus.disp_down_10 = 0; bus.disp_down_25 = 0;
  endtask

  task automatic drive_coins(input bit c5, input bit c10, input bit c25);
    bus.coin_5 = c5; bus.coin_10 = c10; bus.coin_25 = c25;
    step();
    bus.coin_5 = 0; bus.coin_10 = 0; bus.coin_25 = 0;
  endtask

  task automatic drive_down(input int u);
    bus.disp_down_5 = (u == 1); bus.disp_down_10 = (u == 2); bus.disp_down_25 = (u == 5);
    step();
    bus.disp_down_5 = 0; bus.disp_down_10 = 0; bus.disp_down_25 = 0;
  endtask

  task automatic pulse_return();
    bus.coin_return = 1;
    step();
    bus.coin_return = 0;
  endtask

  // Watch the hopper until the controller stops being busy.
  task automatic collect_refund(input int limit);
    got_coin.delete(); got_cyc.delete(); got_cred.delete();
    multi = 0; timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (int'(bus.ret_5) + int'(bus.ret_10) + int'(bus.ret_25) > 1) multi = 1;
      if (bus.ret_25)      begin got_coin.push_back(25); got_cyc.push_back(cyc); got_cred.push_back(int'(bus.credit)); end
      else if (bus.ret_10) begin got_coin.push_back(10); got_cyc.push_back(cyc); got_cred.push_back(int'(bus.credit)); end
      else if (bus.ret_5)  begin got_coin.push_back(5);  got_cyc.push_back(cyc); got_cred.push_back(int'(bus.credit)); end
      if (!bus.busy) begin timed_out = 0; break; end
    end
  endtask

  function automatic string greedy_str(input int c);
    string s = "";
    int n25 = c / 5;
    int n10 = (c % 5) / 2;
    int n5  = (c % 5) % 2;
    for (int i = 0; i < n25; i++) s = {s, "25 "};
    for (int i = 0; i < n10; i++) s = {s, "10 "};
    for (int i = 0; i < n5;  i++) s = {s, "5 "};
    return s;
  endfunction

  function automatic string got_str();
    string s = "";
    foreach (got_coin[i]) s = {s, $sformatf("%0d ", got_coin[i])};
    return s;
  endfunction

  function automatic int bad_gaps();
    int n = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i-1] != PACE) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    checks++; if (bus.disp_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %b want 0", bus.disp_enable); end
    checks++; if (bus.credit !== 6'd0) begin errors++; $display("FAIL rst_credit got %0d want 0", bus.credit); end
    checks++; if ({bus.ret_25, bus.ret_10, bus.ret_5} !== 3'b000) begin errors++; $display("FAIL rst_ret got %b want 000", {bus.ret_25, bus.ret_10, bus.ret_5}); end
    checks++; if ({bus.coin_reject, bus.busy, bus.fault} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.coin_reject, bus.busy, bus.fault}); end
    reset = 0;
    step();
    checks++; if ({bus.disp_enable, bus.busy, bus.credit} !== 8'd0) begin errors++; $display("FAIL rst_idle got %b want 0", {bus.disp_enable, bus.busy, bus.credit}); end
  endtask

  task automatic test_vend_basic();
    int entry;
    drive_coins(0, 0, 1); drive_coins(0, 0, 1); drive_coins(0, 1, 0);
    checks++; if (bus.credit !== 6'd12) begin errors++; $display("FAIL basic_credit got %0d want 12", bus.credit); end
    checks++; if ({bus.disp_enable, bus.busy} !== 2'b10) begin errors++; $display("FAIL basic_credit_state got %b want 10", {bus.disp_enable, bus.busy}); end
    drive_down(5);
    checks++; if ({bus.credit, bus.disp_enable, bus.busy} !== {6'd7, 2'b11}) begin errors++; $display("FAIL basic_down25 got credit %0d en %b busy %b want 7 1 1", bus.credit, bus.disp_enable, bus.busy); end
    drive_down(2);
    checks++; if (bus.credit !== 6'd5) begin errors++; $display("FAIL basic_down10 got %0d want 5", bus.credit); end
    bus.disp_done = 1; step(); bus.disp_done = 0;
    entry = cyc;
    checks++; if ({bus.disp_enable, bus.busy} !== 2'b01) begin errors++; $display("FAIL basic_refund_entry got %b want 01", {bus.disp_enable, bus.busy}); end
    collect_refund(100);
    checks++; if (got_str() != "25 " || timed_out) begin errors++; $display("FAIL basic_change got '%s' timeout %0d want '25 '", got_str(), timed_out); end
    checks++; if (got_cyc.size() < 1 || got_cyc[0] != entry + 1) begin errors++; $display("FAIL basic_first_pulse got %0d want %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, entry + 1); end
    checks++; if ({bus.credit, bus.disp_enable} !== 7'd0) begin errors++; $display("FAIL basic_idle got credit %0d en %b want 0 0", bus.credit, bus.disp_enable); end
  endtask

  task automatic test_return_order();
    int entry;
    drive_coins(1, 1, 1);
    checks++; if (bus.credit !== 6'd8) begin errors++; $display("FAIL ret_credit got %0d want 8", bus.credit); end
    pulse_return();
    entry = cyc;
    collect_refund(200);
    checks++; if (got_str() != "25 10 5 " || timed_out) begin errors++; $display("FAIL ret_order got '%s' timeout %0d want '25 10 5 '", got_str(), timed_out); end
    checks++; if (bad_gaps() != 0 || multi) begin errors++; $display("FAIL ret_pacing got %0d bad gaps multi %0d want 0 0", bad_gaps(), multi); end
    checks++; if (got_cyc.size() < 1 || got_cyc[0] != entry + 1) begin errors++; $display("FAIL ret_first_pulse got %0d want %0d", (got_cyc.size() > 0) ? got_cyc[0] : -1, entry + 1); end
    checks++; if (got_cred.size() != 3 || got_cred[0] != 3 || got_cred[1] != 1 || got_cred[2] != 0) begin errors++; $display("FAIL ret_debit got %0d entries want credits 3 1 0", got_cred.size()); end
    checks++; if (bus.credit !== 6'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ret_idle got credit %0d busy %b want 0 0", bus.credit, bus.busy); end
  endtask

  task automatic test_overflow();
    drive_coins(1, 1, 0);
    checks++; if (bus.credit !== 6'd3 || bus.coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_sum got %0d rej %b want 3 0", bus.credit, bus.coin_reject); end
    repeat (11) drive_coins(0, 0, 1);
    drive_coins(0, 1, 0);
    checks++; if (bus.credit !== 6'd60) begin errors++; $display("FAIL ovf_build got %0d want 60", bus.credit); end
    drive_coins(0, 0, 1);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd60) begin errors++; $display("FAIL ovf_reject got rej %b credit %0d want 1 60", bus.coin_reject, bus.credit); end
    step();
    checks++; if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_reject_width got %b want 0", bus.coin_reject); end
    drive_coins(1, 1, 0);
    checks++; if (bus.credit !== 6'd63 || bus.coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_exact63 got %0d rej %b want 63 0", bus.credit, bus.coin_reject); end
    drive_coins(1, 0, 0);
    checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd63) begin errors++; $display("FAIL ovf_reject63 got rej %b credit %0d want 1 63", bus.coin_reject, bus.credit); end
    pulse_return();
    collect_refund(200);
    checks++; if (got_str() != greedy_str(63) || timed_out) begin errors++; $display("FAIL ovf_refund got '%s' want '%s'", got_str(), greedy_str(63)); end
  endtask

  task automatic test_timeout();
    int mark;
    drive_coins(0, 1, 0);
    mark = cyc;
    for (int i = 0; i < TPS * TOS + 100; i++) begin step(); if (bus.busy) break; end
    checks++; if (bus.busy !== 1'b1 || cyc - mark != TPS * TOS) begin errors++; $display("FAIL tmo_coin got busy %b after %0d cycles want 1 after %0d", bus.busy, cyc - mark, TPS * TOS); end
    checks++; if (bus.credit !== 6'd2 || bus.disp_enable !== 1'b0) begin errors++; $display("FAIL tmo_entry got credit %0d en %b want 2 0", bus.credit, bus.disp_enable); end
    collect_refund(100);
    checks++; if (got_str() != "10 " || timed_out) begin errors++; $display("FAIL tmo_change got '%s' want '10 '", got_str()); end
    drive_coins(0, 1, 0);
    repeat (6000) step();
    bus.disp_failed = 1; step(); bus.disp_failed = 0;
    mark = cyc;
    checks++; if ({bus.credit, bus.disp_enable, bus.busy} !== {6'd2, 2'b10}) begin errors++; $display("FAIL tmo_failed got credit %0d en %b busy %b want 2 1 0", bus.credit, bus.disp_enable, bus.busy); end
    for (int i = 0; i < TPS * TOS + 100; i++) begin step(); if (bus.busy) break; end
    checks++; if (bus.busy !== 1'b1 || cyc - mark != TPS * TOS) begin errors++; $display("FAIL tmo_restart got busy %b after %0d cycles want 1 after %0d", bus.busy, cyc - mark, TPS * TOS); end
    collect_refund(100);
  endtask

  task automatic test_underflow_and_reset();
    int seen;
    drive_coins(1, 0, 0);
    drive_down(5);
    checks++; if (bus.credit !== 6'd0 || bus.fault !== 1'b1) begin errors++; $display("FAIL uf_clamp got credit %0d fault %b want 0 1", bus.credit, bus.fault); end
    bus.disp_done = 1; step(); bus.disp_done = 0;
    checks++; if ({bus.busy, bus.disp_enable, bus.fault} !== 3'b001) begin errors++; $display("FAIL uf_idle got %b want 001", {bus.busy, bus.disp_enable, bus.fault}); end
    drive_coins(0, 0, 1); drive_coins(0, 0, 1);
    checks++; if (bus.credit !== 6'd10 || bus.fault !== 1'b1) begin errors++; $display("FAIL uf_sticky got credit %0d fault %b want 10 1", bus.credit, bus.fault); end
    pulse_return();
    checks++; if (bus.busy !== 1'b1 || bus.credit !== 6'd10) begin errors++; $display("FAIL rstmid_entry got busy %b credit %0d want 1 10", bus.busy, bus.credit); end
    reset = 1;
    #1;
    checks++; if ({bus.disp_enable, bus.credit, bus.ret_25, bus.ret_10, bus.ret_5, bus.coin_reject, bus.busy, bus.fault} !== 13'd0) begin errors++; $display("FAIL rstmid_async got credit %0d busy %b fault %b want all zero", bus.credit, bus.busy, bus.fault); end
    step();
    reset = 0;
    seen = 0;
    for (int i = 0; i < 4 * PACE; i++) begin step(); if (bus.ret_5 || bus.ret_10 || bus.ret_25) seen++; end
    checks++; if (seen != 0 || bus.credit !== 6'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got %0d pulses credit %0d want 0 0", seen, bus.credit); end
  endtask

  task automatic test_random();
    int m, n, s, act, np, u;
    bit c5, c10, c25, rej;
    int opts[$];
    for (int it = 0; it < 24; it++) begin
      m = 0;
      n = $urandom_range(1, 14);
      for (int j = 0; j < n; j++) begin
        c5 = 1'($urandom_range(0, 1)); c10 = 1'($urandom_range(0, 1)); c25 = 1'($urandom_range(0, 1));
        s = int'(c5) + 2 * int'(c10) + 5 * int'(c25);
        rej = (s > 0) && (m + s > 63);
        if (s > 0 && !rej) m += s;
        drive_coins(c5, c10, c25);
        checks++; if (bus.credit !== 6'(m) || bus.coin_reject !== rej) begin errors++; $display("FAIL rnd_coin it %0d got credit %0d rej %b want %0d %b", it, bus.credit, bus.coin_reject, m, rej); end
      end
      if (m == 0) begin drive_coins(1, 0, 0); m = 1; end
      act = $urandom_range(0, 2);
      if (act == 0) begin
        c25 = 1'($urandom_range(0, 1));
        if (c25 && m + 5 <= 63) m += 5;
        bus.coin_25 = c25; pulse_return(); bus.coin_25 = 0;
      end else begin
        np = $urandom_range(1, 3);
        for (int k = 0; k < np; k++) begin
          opts.delete();
          if (m >= 1) opts.push_back(1);
          if (m >= 2) opts.push_back(2);
          if (m >= 5) opts.push_back(5);
          if (opts.size() == 0) break;
          u = opts[$urandom_range(0, opts.size() - 1)];
          drive_down(u);
          m -= u;
          checks++; if (bus.credit !== 6'(m) || {bus.disp_enable, bus.busy} !== 2'b11) begin errors++; $display("FAIL rnd_charge it %0d got credit %0d en %b busy %b want %0d 1 1", it, bus.credit, bus.disp_enable, bus.busy, m); end
          if (k == 0 && $urandom_range(0, 1) == 1) begin
            drive_coins(0, 1, 0);
            checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 6'(m)) begin errors++; $display("FAIL rnd_vend_coin it %0d got rej %b credit %0d want 1 %0d", it, bus.coin_reject, bus.credit, m); end
          end
        end
        if (act == 1) begin
          bus.disp_done = 1; step(); bus.disp_done = 0;
          checks++; if ({bus.disp_enable, bus.busy} !== {1'b0, m > 0}) begin errors++; $display("FAIL rnd_done it %0d got en %b busy %b want 0 %0d", it, bus.disp_enable, bus.busy, m > 0); end
        end else begin
          bus.disp_failed = 1; step(); bus.disp_failed = 0;
          checks++; if ({bus.disp_enable, bus.busy} !== 2'b10 || bus.credit !== 6'(m)) begin errors++; $display("FAIL rnd_failed it %0d got en %b busy %b credit %0d want 1 0 %0d", it, bus.disp_enable, bus.busy, bus.credit, m); end
          pulse_return();
        end
      end
      if (bus.busy) collect_refund(500);
      else begin got_coin.delete(); got_cyc.delete(); timed_out = 0; multi = 0; end
      checks++; if (got_str() != greedy_str(m) || timed_out || multi || bad_gaps() != 0) begin errors++; $display("FAIL rnd_refund it %0d got '%s' want '%s' gaps %0d", it, got_str(), greedy_str(m), bad_gaps()); end
      checks++; if ({bus.credit, bus.busy, bus.disp_enable} !== 8'd0) begin errors++; $display("FAIL rnd_idle it %0d got credit %0d busy %b", it, bus.credit, bus.busy); end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_vend_basic();
    test_return_order();
    test_overflow();
    test_timeout();
    test_underflow_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
